// File: rtl/dnn_fc_layer_seq.sv
// Time-multiplexed fully-connected layer: one input element per cycle into N_OUT signed
// accumulators, then saturated (optionally ReLU-clamped) results behind a valid/ready handshake.
module dnn_fc_layer_seq #(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned N_OUT = 2,
   parameter int unsigned X_W   = 7,
   parameter int unsigned W_W   = 5,
   parameter int unsigned ACC_W = 20,
   parameter int unsigned RELU  = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_IN*X_W-1:0]         x_flat,
   input  logic [N_IN*N_OUT*W_W-1:0]   w_flat,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N_OUT*ACC_W-1:0]      out_flat,
   output logic                        busy
);

   localparam int unsigned AW = X_W + W_W + $clog2(N_IN) + 1;
   localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned EW = (AW > ACC_W) ? AW : ACC_W;
   localparam logic [EW-1:0] SatMax = (EW'(1) << (ACC_W - 1)) - EW'(1);
   localparam logic [EW-1:0] SatMin = ~SatMax;

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e                      state_q, state_d;
   logic [N_IN*X_W-1:0]         x_q, x_d;
   logic [N_IN*N_OUT*W_W-1:0]   w_q, w_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic signed [AW-1:0]        acc_q [N_OUT];
   logic signed [AW-1:0]        acc_d [N_OUT];
   logic signed [AW-1:0]        acc_sum [N_OUT];
   logic [N_OUT*ACC_W-1:0]      out_q, out_d;
   logic signed [X_W-1:0]       x_sel;
   logic signed [W_W-1:0]       w_sel [N_OUT];

   // Clamp to the ACC_W range in a width wide enough for both the accumulator and the output.
   function automatic logic [ACC_W-1:0] sat_relu(input logic signed [AW-1:0] a);
      logic signed [EW-1:0] e;
      logic signed [EW-1:0] r;
      e = EW'(a);
      if (e > $signed(SatMax)) begin
         r = $signed(SatMax);
      end else if (e < $signed(SatMin)) begin
         r = $signed(SatMin);
      end else begin
         r = e;
      end
      if ((RELU != 0) && r[EW-1]) begin
         r = '0;
      end
      return r[ACC_W-1:0];
   endfunction

   always_comb begin
      x_sel = x_q[int'(idx_q)*X_W +: X_W];
      for (int j = 0; j < N_OUT; j++) begin
         w_sel[j]   = w_q[(j*N_IN + int'(idx_q))*W_W +: W_W];
         acc_sum[j] = acc_q[j] + AW'(x_sel) * AW'(w_sel[j]);
      end
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      w_d       = w_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      out_d     = out_q;
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      busy      = (state_q != StIdle);
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               x_d     = x_flat;
               w_d     = w_flat;
               idx_d   = '0;
               state_d = StAccum;
               for (int j = 0; j < N_OUT; j++) acc_d[j] = '0;
            end
         end
         StAccum: begin
            acc_d = acc_sum;
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(N_IN - 1)) begin
               state_d = StDone;
               for (int j = 0; j < N_OUT; j++) out_d[j*ACC_W +: ACC_W] = sat_relu(acc_sum[j]);
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         x_q     <= '0;
         w_q     <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         for (int j = 0; j < N_OUT; j++) acc_q[j] <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         w_q     <= w_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         for (int j = 0; j < N_OUT; j++) acc_q[j] <= acc_d[j];
      end
   end

   assign out_flat = out_q;

endmodule

// File: tb/tb_dnn_fc_layer_seq.sv
// Bench for dnn_fc_layer_seq: three instances (plain, ReLU, 8-bit output) share one stimulus
// stream and are checked against an arithmetic dot-product/clamp model.
module tb_dnn_fc_layer_seq;

   localparam int NI = 4;
   localparam int NO = 2;
   localparam int XW = 7;
   localparam int WW = 5;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 out_ready = 1'b1;
   logic [NI*XW-1:0]     x_flat = '0;
   logic [NI*NO*WW-1:0]  w_flat = '0;
   logic                 in_ready0, in_ready1, in_ready2;
   logic                 out_valid0, out_valid1, out_valid2;
   logic                 busy0, busy1, busy2;
   logic [NO*20-1:0]     out0, out1;
   logic [NO*8-1:0]      out2;

   int n_cmp = 0;
   int n_err = 0;
   int cx[NI];
   int cw[NI][NO];

   always #5 clk = ~clk;

   dnn_fc_layer_seq #(.N_IN(NI), .N_OUT(NO), .X_W(XW), .W_W(WW), .ACC_W(20), .RELU(0)) u_plain (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .x_flat(x_flat),
      .w_flat(w_flat), .out_valid(out_valid0), .out_ready(out_ready), .out_flat(out0),
      .busy(busy0));

   dnn_fc_layer_seq #(.N_IN(NI), .N_OUT(NO), .X_W(XW), .W_W(WW), .ACC_W(20), .RELU(1)) u_relu (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .x_flat(x_flat),
      .w_flat(w_flat), .out_valid(out_valid1), .out_ready(out_ready), .out_flat(out1),
      .busy(busy1));

   dnn_fc_layer_seq #(.N_IN(NI), .N_OUT(NO), .X_W(XW), .W_W(WW), .ACC_W(8), .RELU(0)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .x_flat(x_flat),
      .w_flat(w_flat), .out_valid(out_valid2), .out_ready(out_ready), .out_flat(out2),
      .busy(busy2));

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint model(input int xs[NI], input int ws[NI][NO], input int j,
                                    input int accw, input bit relu);
      longint s = 0;
      longint hi = (longint'(1) << (accw - 1)) - 1;
      longint lo = -(longint'(1) << (accw - 1));
      for (int i = 0; i < NI; i++) s += longint'(xs[i]) * longint'(ws[i][j]);
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      if (relu && s < 0) s = 0;
      return s;
   endfunction

   task automatic load(input int xs[NI], input int ws[NI][NO]);
      for (int i = 0; i < NI; i++) begin
         x_flat[i*XW +: XW] = XW'(xs[i]);
         for (int j = 0; j < NO; j++) w_flat[(j*NI + i)*WW +: WW] = WW'(ws[i][j]);
      end
   endtask

   task automatic rand_vec();
      for (int i = 0; i < NI; i++) begin
         cx[i] = int'($urandom_range(0, 127)) - 64;
         for (int j = 0; j < NO; j++) cw[i][j] = int'($urandom_range(0, 31)) - 16;
      end
   endtask

   task automatic check_outs(input string tag, input int xs[NI], input int ws[NI][NO]);
      for (int j = 0; j < NO; j++) begin
         check($sformatf("%s plain[%0d]", tag, j), longint'($signed(out0[j*20 +: 20])),
               model(xs, ws, j, 20, 1'b0));
         check($sformatf("%s relu[%0d]", tag, j), longint'($signed(out1[j*20 +: 20])),
               model(xs, ws, j, 20, 1'b1));
         check($sformatf("%s sat8[%0d]", tag, j), longint'($signed(out2[j*8 +: 8])),
               model(xs, ws, j, 8, 1'b0));
      end
   endtask

   // Offers cx/cw, waits for its result, checks latency and values, completes the handshake.
   task automatic run_vec(input string tag);
      int t;
      int k;
      load(cx, cw);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({tag, " accept"}, longint'(in_ready0), 1);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " busy"}, longint'({busy0, busy1, busy2, in_ready0}), 4'b1110);
      k = 1;
      while (!out_valid0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, " latency"}, k, NI + 1);
      check({tag, " valid all"}, longint'({out_valid0, out_valid1, out_valid2}), 3'b111);
      check_outs(tag, cx, cw);
      @(negedge clk);
      check({tag, " valid drop"}, longint'(out_valid0), 0);
   endtask

   initial begin
      int ax[NI];
      int aw[NI][NO];
      int sx[3][NI];
      int sw[3][NI][NO];
      int t;
      int k;
      int seen;
      int vi;
      int ri;
      int last;

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset ready/valid/busy", longint'({in_ready0, out_valid0, busy0}), 3'b100);
      check("reset out_flat", longint'(out0), 0);
      check("reset sat out_flat", longint'(out2), 0);

      // Nominal vector
      cx = '{4, 2, 4, 1};
      cw = '{'{3, -9}, '{2, 1}, '{13, -4}, '{-6, 14}};
      run_vec("nominal");
      check("nominal out0 const", longint'($signed(out0[19:0])), 62);

      // Saturation on the 8-bit instance
      for (int i = 0; i < NI; i++) begin
         cx[i] = 63;
         for (int j = 0; j < NO; j++) cw[i][j] = 15;
      end
      run_vec("sat_pos");
      check("sat_pos const", longint'($signed(out2[7:0])), 127);
      for (int i = 0; i < NI; i++) cx[i] = -64;
      run_vec("sat_neg");
      check("sat_neg const", longint'($signed(out2[15:8])), -128);

      // Random vectors
      for (int n = 0; n < 8; n++) begin
         rand_vec();
         run_vec($sformatf("rand%0d", n));
      end

      // Back-pressure with a second vector waiting
      rand_vec();
      ax = cx;
      aw = cw;
      out_ready = 1'b0;
      load(ax, aw);
      in_valid = 1'b1;
      @(negedge clk);
      rand_vec();
      load(cx, cw);
      t = 0;
      while (!out_valid0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("bp valid rise", longint'(out_valid0), 1);
      for (int c = 0; c < 6; c++) begin
         check_outs($sformatf("bp hold%0d", c), ax, aw);
         check($sformatf("bp hs%0d", c), longint'({in_ready0, out_valid0}), 2'b01);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp release", longint'({in_ready0, out_valid0, busy0}), 3'b100);
      check_outs("bp after", ax, aw);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp B accepted", longint'(busy0), 1);
      k = 1;
      while (!out_valid0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("bp B latency", k, NI + 1);
      check_outs("bp B", cx, cw);
      @(negedge clk);

      // Reset in the second ACCUM cycle
      cx = '{4, 2, 4, 1};
      cw = '{'{3, -9}, '{2, 1}, '{13, -4}, '{-6, 14}};
      load(cx, cw);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst state", longint'({in_ready0, busy0, out_valid0}), 3'b100);
      check("midrst out_flat", longint'(out0), 0);
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid0 || out_valid1 || out_valid2) seen++;
         @(negedge clk);
      end
      check("midrst no valid", seen, 0);
      run_vec("post_rst");

      // Back-to-back streaming of three vectors
      for (int v = 0; v < 3; v++) begin
         rand_vec();
         sx[v] = cx;
         sw[v] = cw;
      end
      vi = 0;
      ri = 0;
      last = 0;
      for (int cyc = 0; cyc < 80 && ri < 3; cyc++) begin
         if (out_valid0) begin
            check_outs($sformatf("stream%0d", ri), sx[ri], sw[ri]);
            if (ri > 0) check($sformatf("stream gap%0d", ri), cyc - last, NI + 2);
            last = cyc;
            ri++;
         end
         if (in_ready0 && vi < 3) begin
            load(sx[vi], sw[vi]);
            in_valid = 1'b1;
            vi++;
         end else if (in_ready0) begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("stream count", ri, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
